// File: rtl/flash_play_ctrl.sv
// Playback sequencer: fetches 32-bit words from flash over Avalon-MM and
// presents them as two 16-bit samples, one per sample tick.
module flash_play_ctrl #(
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_fwd,
    input  logic              cmd_bwd,
    input  logic              cmd_restart,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [15:0]       audio_data,
    output logic              sample_strobe,
    output logic              playing,
    output logic              dir_fwd,
    output logic              underrun,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_HOLD0     = 3'd3,
        S_HOLD1     = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              word_fwd;
    logic              restart_pend;

    logic              tick_ok;
    logic              load_word;
    logic              emit0;
    logic              emit1;
    logic              do_reload;
    logic              do_advance;
    logic              set_pend;
    logic              clr_pend;
    logic              under_n;
    logic [ADDR_W-1:0] reload_val;
    logic [ADDR_W-1:0] adv_val;

    // Avalon read: flash_read and flash_address stay stable in FETCH until a
    // cycle with flash_waitrequest low accepts the request; the word comes
    // back later on flash_readdatavalid and is never cancelled.
    assign flash_read    = (state == S_FETCH);
    assign flash_address = addr;
    assign state_dbg     = state;

    // Restart outranks pause, and pause outranks a tick arriving with it.
    assign tick_ok    = sample_tick && playing && !cmd_pause && !cmd_restart;
    assign reload_val = dir_fwd ? START_ADDR : END_ADDR;

    always_comb begin
        adv_val = addr;
        if (dir_fwd) begin
            adv_val = (addr == END_ADDR) ? START_ADDR : addr + 1'b1;
        end else begin
            adv_val = (addr == START_ADDR) ? END_ADDR : addr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        load_word  = 1'b0;
        emit0      = 1'b0;
        emit1      = 1'b0;
        do_reload  = 1'b0;
        do_advance = 1'b0;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        under_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_restart) begin
                    do_reload = 1'b1;
                end else if (cmd_play && !cmd_pause) begin
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cmd_restart) set_pend = 1'b1;
                if (tick_ok) under_n = 1'b1;
                if (!flash_waitrequest) state_n = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (tick_ok) under_n = 1'b1;
                if (flash_readdatavalid) begin
                    load_word = 1'b1;
                    if (restart_pend || cmd_restart) begin
                        clr_pend  = 1'b1;
                        do_reload = 1'b1;
                        state_n   = S_FETCH;
                    end else begin
                        state_n = S_HOLD0;
                    end
                end else if (cmd_restart) begin
                    set_pend = 1'b1;
                end
            end
            S_HOLD0: begin
                if (cmd_restart) begin
                    do_reload = 1'b1;
                    state_n   = S_FETCH;
                end else if (tick_ok) begin
                    emit0   = 1'b1;
                    state_n = S_HOLD1;
                end
            end
            S_HOLD1: begin
                if (cmd_restart) begin
                    do_reload = 1'b1;
                    state_n   = S_FETCH;
                end else if (tick_ok) begin
                    emit1      = 1'b1;
                    do_advance = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= START_ADDR;
            word          <= 32'h0;
            word_fwd      <= 1'b1;
            restart_pend  <= 1'b0;
            audio_data    <= 16'h0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
            playing       <= 1'b0;
            dir_fwd       <= 1'b1;
        end else begin
            sample_strobe <= emit0 | emit1;
            underrun      <= under_n;

            if (do_reload) begin
                addr <= reload_val;
            end else if (do_advance) begin
                addr <= adv_val;
            end

            // The half order is fixed by the direction at the time of capture.
            if (load_word) begin
                word     <= flash_readdata;
                word_fwd <= dir_fwd;
            end

            if (emit0) begin
                audio_data <= word_fwd ? word[15:0] : word[31:16];
            end else if (emit1) begin
                audio_data <= word_fwd ? word[31:16] : word[15:0];
            end

            if (clr_pend) begin
                restart_pend <= 1'b0;
            end else if (set_pend) begin
                restart_pend <= 1'b1;
            end

            if (!cmd_restart) begin
                if (cmd_pause) begin
                    playing <= 1'b0;
                end else if (cmd_play) begin
                    playing <= 1'b1;
                end
            end

            if (cmd_fwd) begin
                dir_fwd <= 1'b1;
            end else if (cmd_bwd) begin
                dir_fwd <= 1'b0;
            end
        end
    end

endmodule
